// File: rtl/bcd_serial_adder.sv
`timescale 1ns/1ps
// bcd_serial_adder: digit-serial packed-BCD adder/subtractor.
// One BCD digit is processed per clock, least significant digit first.
// Subtraction uses the ten's complement: each B digit is replaced by its
// nine's complement and the initial carry is forced to 1.
//
// Handshake: start is sampled only in IDLE; the capture edge latches the
// operands and mode, busy is high for exactly DIGITS cycles (RUN), then
// done pulses for one cycle (DONE) while sum/cout/err carry the result.
// The result outputs hold until the next capture edge clears them.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err,
    output logic [1:0]          dbg_state
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           sub_r;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   sum_r;
    logic           cout_r;
    logic           err_r;

    logic           last_digit;
    logic [3:0]     a_dig;
    logic [3:0]     b_dig;
    logic [3:0]     b_eff;
    logic [4:0]     s;
    logic [3:0]     digit;
    logic           c_next;
    logic           bad;

    assign last_digit = (cnt == CW'(DIGITS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN for DIGITS cycles, one DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_digit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-digit BCD add with decimal correction on the currently selected digit.
    always_comb begin
        a_dig  = a_r[cnt*4 +: 4];
        b_dig  = b_r[cnt*4 +: 4];
        b_eff  = sub_r ? (4'd9 - b_dig) : b_dig;
        s      = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry};
        c_next = 1'b0;
        digit  = s[3:0];
        if (s > 5'd9) begin
            digit  = s[3:0] + 4'd6;
            c_next = 1'b1;
        end
    end

    // Flags any non-decimal nibble in the captured operands.
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a_r[i*4 +: 4] > 4'd9 || b_r[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
    end

    // Operand capture, digit sweep and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            sub_r  <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        sub_r  <= sub;
                        carry  <= sub ? 1'b1 : cin;
                        cnt    <= '0;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                        err_r  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_r[cnt*4 +: 4] <= digit;
                    carry             <= c_next;
                    cnt               <= cnt + CW'(1);
                    if (last_digit) begin
                        if (bad) begin
                            sum_r  <= '0;
                            cout_r <= 1'b0;
                            err_r  <= 1'b1;
                        end else begin
                            cout_r <= c_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign err       = err_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_bcd_serial_adder.sv
`timescale 1ns/1ps
// Bench for bcd_serial_adder (DIGITS=4): directed table, hand sequences for
// back-to-back start, mid-run reset, and randomized ops against a decimal model.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;
  localparam int MOD = 10 ** DIGITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cin = 1'b0;
  logic sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic busy, done, cout, err;
  logic [W-1:0] sum;
  logic [1:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] es;
    logic         ec;
    logic         ee;
  } vec_t;

  vec_t tbl[12];

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---- reference model: plain decimal arithmetic ----
  function automatic bit bad_bcd(input logic [W-1:0] v);
    bad_bcd = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[i*4 +: 4] > 4'd9) bad_bcd = 1'b1;
  endfunction

  function automatic int bcd_val(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s,
                       output logic [W-1:0] es, output logic ec, output logic ee);
    int av, bv, r;
    if (bad_bcd(x) || bad_bcd(y)) begin
      es = '0; ec = 1'b0; ee = 1'b1;
    end else begin
      av = bcd_val(x);
      bv = bcd_val(y);
      ee = 1'b0;
      if (!s) begin
        r  = av + bv + int'(ci);
        ec = (r >= MOD);
        es = to_bcd(r % MOD);
      end else begin
        ec = (av >= bv);
        es = to_bcd((av - bv + MOD) % MOD);
      end
    end
  endtask

  // ---- driver: one operation, returns observed result and timing ----
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s,
                       output logic [W-1:0] rs, output logic rc, output logic re,
                       output int lat, output int bcnt, output int overlap);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0; bcnt = 0; overlap = 0; rs = '1; rc = 1'bx; re = 1'bx;
    for (int k = 1; k <= 3 * DIGITS + 4 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) check("capture clears outputs", {sum, 2'b00, cout, err}, 32'h0);
      if (busy) bcnt++;
      if (busy && done) overlap++;
      if (done) begin
        lat = k; rs = sum; rc = cout; re = err;
      end
    end
  endtask

  task automatic run_check(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic ci, input logic s,
                           input logic [W-1:0] es, input logic ec, input logic ee);
    logic [W-1:0] rs;
    logic rc, re;
    int lat, bcnt, ov;
    do_op(x, y, ci, s, rs, rc, re, lat, bcnt, ov);
    check($sformatf("%s sum", name), 32'(rs), 32'(es));
    check($sformatf("%s cout", name), 32'(rc), 32'(ec));
    check($sformatf("%s err", name), 32'(re), 32'(ee));
    check($sformatf("%s latency", name), lat, DIGITS + 1);
    check($sformatf("%s busy cycles", name), bcnt, DIGITS);
    check($sformatf("%s busy/done overlap", name), ov, 0);
  endtask

  logic [W-1:0] xs, ys, es, rs;
  logic ec, ee, rc, re, ci_r, sb_r;
  int lat, bcnt, ov, dcount, done_seen;

  initial begin
    // stimulus table
    tbl[0]  = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
    tbl[1]  = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2]  = '{16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0};
    tbl[3]  = '{16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3766, 1'b1, 1'b0};
    tbl[4]  = '{16'h1234, 16'h5000, 1'b0, 1'b1, 16'h6234, 1'b0, 1'b0};
    tbl[5]  = '{16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[6]  = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    tbl[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0};
    tbl[9]  = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[10] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[11] = '{16'h0500, 16'h0500, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    // reset: outputs low regardless of clock
    #1;
    check("reset outputs", {sum, 1'b0, busy, done, cout, err}, 32'h0);
    check("reset state", 32'(dbg_state), 32'h0);
    repeat (3) @(negedge clk);
    check("reset outputs held", {sum, 1'b0, busy, done, cout, err}, 32'h0);
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 12; i++)
      run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                tbl[i].es, tbl[i].ec, tbl[i].ee);

    // results hold in IDLE
    repeat (4) @(negedge clk);
    check("hold sum", 32'(sum), 32'h1000);
    check("hold busy/done", {30'h0, busy, done}, 32'h0);

    // start held high, operands wiggling after each capture
    @(negedge clk);
    a = 16'h2222; b = 16'h3333; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    dcount = 0; ov = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (busy && done) ov++;
      if (done) begin
        dcount++;
        if (dcount == 1) begin
          check("hold-start op1 time", k, DIGITS + 1);
          check("hold-start op1 sum", 32'(sum), 32'h5555);
          check("hold-start op1 cout", 32'(cout), 32'h0);
        end else begin
          check("hold-start op2 time", k, 2 * DIGITS + 3);
          check("hold-start op2 sum", 32'(sum), 32'h3001);
          check("hold-start op2 cout", 32'(cout), 32'h1);
        end
      end
      if (k == DIGITS + 2) begin
        a = 16'h4000; b = 16'h0999; sub = 1'b1; cin = 1'($urandom);
      end else begin
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      end
      if (k == 2 * DIGITS + 4) start = 1'b0;
    end
    check("hold-start op count", dcount, 2);
    check("hold-start overlap", ov, 0);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    a = 16'h9876; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-run reset outputs", {sum, 1'b0, busy, done, cout, err}, 32'h0);
    check("mid-run reset state", 32'(dbg_state), 32'h0);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst_n = 1'b1;
    repeat (DIGITS + 4) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("no done after reset", done_seen, 0);
    run_check("post-reset", 16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);

    // randomized operations against the decimal model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        xs[i*4 +: 4] = 4'($urandom_range(0, 9));
        ys[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 9) == 0) xs[$urandom_range(0, DIGITS - 1)*4 +: 4] = 4'($urandom_range(10, 15));
      ci_r = 1'($urandom);
      sb_r = 1'($urandom);
      model(xs, ys, ci_r, sb_r, es, ec, ee);
      exp_q.push_back(es);
      do_op(xs, ys, ci_r, sb_r, rs, rc, re, lat, bcnt, ov);
      check($sformatf("rand%0d sum", n), 32'(rs), 32'(exp_q.pop_front()));
      check($sformatf("rand%0d cout/err", n), {30'h0, rc, re}, {30'h0, ec, ee});
      check($sformatf("rand%0d latency", n), lat, DIGITS + 1);
      check($sformatf("rand%0d busy cycles", n), bcnt, DIGITS);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the number of BCD digits per operand (legal range 1..16).
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request an operation; sampled only in IDLE.
REQ-005 a  input  4*DIGITS  SHALL be operand A, packed BCD, digit 0 in bits [3:0].
REQ-006 b  input  4*DIGITS  SHALL be operand B, same packing.
REQ-007 cin  input  1  SHALL be the decimal carry-in (add mode only).
REQ-008 sub  input  1  SHALL select the mode: 0 = A+B+cin, 1 = A-B.
REQ-009 busy  output  1  SHALL be high while digits are being processed.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking valid results.
REQ-011 sum  output  4*DIGITS  SHALL be the packed BCD result.
REQ-012 cout  output  1  SHALL be the decimal carry-out (add) or the no-borrow flag (sub).
REQ-013 err  output  1  SHALL flag an invalid input digit (nibble > 9) in the captured operands.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 Transition IDLE->RUN occurs on the edge where start=1; that edge SHALL capture a, b, cin and sub into internal registers and clear the digit counter to 0.
REQ-016 Input changes after the capture edge SHALL NOT affect the running operation.
REQ-017 start SHALL be ignored in RUN and DONE.
REQ-018 Each RUN edge SHALL process one digit, LSD first; the counter increments from 0 to DIGITS-1.
REQ-019 Per-digit arithmetic SHALL form s = a_i + b'_i + c, 5 bits wide, with s ranging 0..19.
  - If s > 9: digit = (s + 6)[3:0] and c_next = 1.
  - Else: digit = s[3:0] and c_next = 0.
REQ-020 In add mode, b'_i = b_i and the initial c = cin.
REQ-021 In sub mode, b'_i = 9 - b_i and the initial c = 1 (ten's complement); cin SHALL be ignored.
REQ-022 In sub mode, cout=1 means A >= B. When A < B, sum SHALL be 10^DIGITS - (B - A).
REQ-023 After the edge that processes digit DIGITS-1, the FSM SHALL enter DONE with cout = final c.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 Latency SHALL be fixed: done is high in the cycle following edge T0+DIGITS, where T0 is the capture edge.
REQ-026 Maximum throughput SHALL be one operation per DIGITS+2 cycles.
REQ-027 busy SHALL be 1 exactly during RUN, and 0 in IDLE and DONE.
REQ-028 err SHALL be evaluated from the captured operands (any nibble of a or b > 9).
  - Latency is unchanged when err=1.
  - In DONE with err=1, sum SHALL read 0 and cout SHALL read 0.
REQ-029 sum, cout and err SHALL hold their values from DONE until the next capture edge.
REQ-030 On the capture edge, err SHALL be cleared and sum/cout SHALL be cleared to 0.
REQ-031 done and busy SHALL never be high in the same cycle.

Reset
REQ-032 While rst_n=0, state SHALL be IDLE and busy, done, sum, cout and err SHALL be 0, regardless of clk.
REQ-033 Reset asserted in RUN or DONE SHALL abandon the operation; no done pulse SHALL follow.
REQ-034 The first start after rst_n deasserts SHALL be accepted normally.

Verification
REQ-035 The bench SHALL run with DIGITS=4 and cover the following scenarios:
  - Add, a=0x1234, b=0x5678, cin=0 -> sum=0x6912, cout=0, done in the cycle after edge T0+4, busy high for exactly 4 cycles.
  - Add wrap, a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1; with cin=1, a=0x9999, b=0x9999 -> sum=0x9999, cout=1.
  - Sub, a=0x5000, b=0x1234 -> sum=0x3766, cout=1; then a=0x1234, b=0x5000 -> sum=0x6234, cout=0.
  - Invalid digit, a=0x12A4, b=0x0001 -> err=1, sum=0x0000, cout=0, done at normal latency; next valid start clears err.
  - Hold start high through RUN/DONE with a/b changing after capture -> exactly one operation per DIGITS+2 cycles, results reflect the captured values only.
  - Assert rst_n=0 mid-RUN (between clock edges) -> busy/sum/cout/err drop to 0 immediately, no done pulse; after release, a=0x0005, b=0x0005 -> sum=0x0010, cout=0.
